// File: rtl/serial_comp_pkg.sv
// Shared encodings and sizing helper for the digit-serial magnitude comparator.
// FSM states, the latched per-operand decision, and the digit-counter width.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } res_e;

    // Counter must be able to hold NUM_DIGITS itself, hence n+1.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cmp2_digit.sv
// Combinational 2-bit magnitude comparator for one digit pair.
// Zero latency; no flow control.
module cmp2_digit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_mag_comp.sv
// Digit-serial (2-bit, MSB first) magnitude comparator; done pulses the cycle after the last digit.
// Digits are only taken while busy; dig_valid=0 stalls indefinitely. SERIAL_COMP_EARLY_EXIT_EN
// ends the comparison on the first differing digit instead of consuming the whole operand.
module serial_mag_comp
    import serial_comp_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dig_valid,
    input  logic [1:0] a_dig,
    input  logic [1:0] b_dig,
    output logic       busy,
    output logic       done,
    output logic       greater,
    output logic       lesser,
    output logic       equal
);

    localparam int             CW   = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0]  LAST = CW'(NUM_DIGITS - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    res_e          res_q;
    res_e          res_d;
    logic          busy_q, done_q, gt_q, lt_q, eq_q;
    logic          d_gt, d_lt, d_eq;
    logic          finish_d;

    cmp2_digit u_cmp (
        .a  (a_dig),
        .b  (b_dig),
        .gt (d_gt),
        .lt (d_lt),
        .eq (d_eq)
    );

    // Only the first non-equal digit decides; later digits never override it.
    always_comb begin
        res_d = res_q;
        if (res_q == RES_EQ) begin
            case ({d_gt, d_lt, d_eq})
                3'b100:  res_d = RES_GT;
                3'b010:  res_d = RES_LT;
                default: res_d = RES_EQ;
            endcase
        end
    end

    always_comb begin
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        finish_d = (cnt_q == LAST) || (res_d != RES_EQ);
`else
        finish_d = (cnt_q == LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= RES_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        res_q   <= RES_EQ;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (dig_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                        res_q <= res_d;
                        if (finish_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gt_q    <= (res_d == RES_GT);
                            lt_q    <= (res_d == RES_LT);
                            eq_q    <= (res_d == RES_EQ);
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    // Back-to-back start skips IDLE entirely.
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        res_q   <= RES_EQ;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign greater = gt_q;
    assign lesser  = lt_q;
    assign equal   = eq_q;

endmodule
